// File: rtl/hd_dma_controller.sv
// hd_dma_controller: single-command block mover between the hard-disk port and
// the data memory. Load (disk->memory) takes 2 cycles/word because the disk read
// data is registered; store (memory->disk) takes 1 cycle/word because the memory
// read is combinational. Range errors and zero-length commands finish in DONE
// without touching either side.
// Optional build macro HDC_CHECKSUM_EN: running mod-2^DATA_WIDTH sum of every
// transferred word; when undefined the checksum output is tied to zero.
module hd_dma_controller #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 1024,
    parameter int TRACKS     = 4
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  cmdValid,
    output logic                  cmdReady,
    input  logic                  cmdWrite,
    input  logic [DATA_WIDTH-1:0] cmdTrack,
    input  logic [DATA_WIDTH-1:0] cmdTrackPos,
    input  logic [DATA_WIDTH-1:0] cmdMemAddr,
    input  logic [DATA_WIDTH-1:0] cmdLength,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] checksum,
    output logic [DATA_WIDTH-1:0] hdTrack,
    output logic [DATA_WIDTH-1:0] hdTrackPos,
    output logic [DATA_WIDTH-1:0] hdWriteData,
    output logic                  hdFlag,
    input  logic [DATA_WIDTH-1:0] hdReadData,
    output logic [DATA_WIDTH-1:0] memAddress,
    output logic [DATA_WIDTH-1:0] memWriteData,
    output logic                  memWrite,
    input  logic [DATA_WIDTH-1:0] memReadData
);

    localparam int TPW = ADDR_WIDTH / TRACKS;
    // Wide enough that track*TPW + pos + length can never wrap.
    localparam int EW  = 2 * DATA_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_ADDR,
        S_LOAD_DATA,
        S_STORE,
        S_DONE
    } state_t;

    state_t r_state, w_next;

    logic [DATA_WIDTH-1:0] r_track, r_pos, r_mem, r_remain;
    logic                  r_err;

    logic          w_accept, w_range_bad, w_len_zero, w_last, w_adv;
    logic [EW-1:0] w_end;

    assign w_accept    = (r_state == S_IDLE) && cmdValid;
    assign w_end       = EW'(cmdTrack) * EW'(TPW) + EW'(cmdTrackPos) + EW'(cmdLength);
    assign w_range_bad = (cmdTrack >= DATA_WIDTH'(TRACKS)) ||
                         (cmdTrackPos >= DATA_WIDTH'(TPW)) ||
                         (w_end > EW'(ADDR_WIDTH));
    assign w_len_zero  = (cmdLength == '0);
    assign w_last      = (r_remain == DATA_WIDTH'(1));
    assign w_adv       = (r_state == S_STORE) || (r_state == S_LOAD_DATA);

    assign hdTrack    = r_track;
    assign hdTrackPos = r_pos;
    assign memAddress = r_mem;
    assign error      = r_err;

    // State register.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // Next-state decode and per-state strobes / data steering.
    always_comb begin
        w_next       = r_state;
        cmdReady     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        hdFlag       = 1'b0;
        memWrite     = 1'b0;
        hdWriteData  = '0;
        memWriteData = '0;
        case (r_state)
            S_IDLE: begin
                cmdReady = 1'b1;
                if (cmdValid) begin
                    if (w_range_bad || w_len_zero) w_next = S_DONE;
                    else if (cmdWrite)             w_next = S_STORE;
                    else                           w_next = S_LOAD_ADDR;
                end
            end
            S_LOAD_ADDR: begin
                busy   = 1'b1;
                w_next = S_LOAD_DATA;
            end
            S_LOAD_DATA: begin
                busy         = 1'b1;
                memWrite     = 1'b1;
                memWriteData = hdReadData;
                w_next       = w_last ? S_DONE : S_LOAD_ADDR;
            end
            S_STORE: begin
                busy        = 1'b1;
                hdFlag      = 1'b1;
                hdWriteData = memReadData;
                w_next      = w_last ? S_DONE : S_STORE;
            end
            S_DONE: begin
                done   = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Latch the command at accept, then step addresses once per transferred word.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_track  <= '0;
            r_pos    <= '0;
            r_mem    <= '0;
            r_remain <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_track  <= cmdTrack;
            r_pos    <= cmdTrackPos;
            r_mem    <= cmdMemAddr;
            r_remain <= cmdLength;
            r_err    <= w_range_bad;
        end else if (w_adv) begin
            r_mem    <= r_mem + 1'b1;
            r_remain <= r_remain - 1'b1;
            if (r_pos == DATA_WIDTH'(TPW - 1)) begin
                r_pos   <= '0;
                r_track <= r_track + 1'b1;
            end else begin
                r_pos   <= r_pos + 1'b1;
            end
        end
    end

`ifdef HDC_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_sum;

    // Running sum of transferred words; cleared on accept, held after done.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN)       r_sum <= '0;
        else if (w_accept) r_sum <= '0;
        else if (hdFlag)   r_sum <= r_sum + hdWriteData;
        else if (memWrite) r_sum <= r_sum + memWriteData;
    end

    assign checksum = r_sum;
`else
    assign checksum = '0;
`endif

endmodule

// File: tb/tb_hd_dma_controller.sv
// Scoreboard bench for hd_dma_controller: the stimulus thread pushes expected
// memory writes, disk writes and done records; a negedge monitor pops and
// compares them as the DUT produces them. Disk and memory are behavioural.
module tb_hd_dma_controller;

    logic        clock = 1'b0;
    logic        resetN;
    logic        cmdValid, cmdReady, cmdWrite;
    logic [31:0] cmdTrack, cmdTrackPos, cmdMemAddr, cmdLength;
    logic        busy, done, error;
    logic [31:0] checksum, hdTrack, hdTrackPos, hdWriteData, hdReadData;
    logic        hdFlag;
    logic [31:0] memAddress, memWriteData, memReadData;
    logic        memWrite;

    hd_dma_controller #(.DATA_WIDTH(32), .ADDR_WIDTH(1024), .TRACKS(4)) dut (
        .clock(clock), .resetN(resetN),
        .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdWrite(cmdWrite),
        .cmdTrack(cmdTrack), .cmdTrackPos(cmdTrackPos),
        .cmdMemAddr(cmdMemAddr), .cmdLength(cmdLength),
        .busy(busy), .done(done), .error(error), .checksum(checksum),
        .hdTrack(hdTrack), .hdTrackPos(hdTrackPos), .hdWriteData(hdWriteData),
        .hdFlag(hdFlag), .hdReadData(hdReadData),
        .memAddress(memAddress), .memWriteData(memWriteData),
        .memWrite(memWrite), .memReadData(memReadData)
    );

    always #5 clock = ~clock;

`ifdef HDC_CHECKSUM_EN
    localparam bit CS = 1'b1;
`else
    localparam bit CS = 1'b0;
`endif

    // ---------------- behavioural disk and memory ----------------
    logic [31:0] disk [0:1023];
    logic [31:0] mem  [0:255];
    logic [9:0]  w_didx;

    assign w_didx      = {hdTrack[1:0], hdTrackPos[7:0]};
    assign memReadData = mem[memAddress[7:0]];

    always @(posedge clock) begin
        hdReadData <= disk[w_didx];
        if (hdFlag)   disk[w_didx] <= hdWriteData;
        if (memWrite) mem[memAddress[7:0]] <= memWriteData;
    end

    // ---------------- scoreboard ----------------
    typedef struct {
        int          kind;   // 0 mem write, 1 disk write, 2 done
        int          addr;
        logic [31:0] data;
        logic        err;
    } ev_t;

    ev_t q[$];
    int  total = 0;
    int  bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push(input int kind, input int addr, input logic [31:0] data, input logic err);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data; e.err = err;
        q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input int addr, input logic [31:0] data, input logic err);
        ev_t e;
        if (q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_event: got kind %0d addr %0d data %0h want none", kind, addr, data);
        end else begin
            e = q.pop_front();
            chk("ev_kind", 32'(kind), 32'(e.kind));
            chk("ev_addr", 32'(addr), 32'(e.addr));
            chk("ev_data", data, e.data);
            chk("ev_err",  {31'd0, err}, {31'd0, e.err});
        end
    endtask

    // Monitor: every observed transfer or completion must match the queue head.
    always @(negedge clock) begin
        if (resetN === 1'b1) begin
            if (memWrite && hdFlag) chk("flag_overlap", 32'd1, 32'd0);
            if (memWrite) check_ev(0, int'(memAddress), memWriteData, 1'b0);
            if (hdFlag)   check_ev(1, int'(hdTrack * 32'd256 + hdTrackPos), hdWriteData, 1'b0);
            if (done)     check_ev(2, 0, checksum, error);
        end
    end

    // ---------------- stimulus ----------------
    // Issue one command at #1 after a rising edge; sample each following cycle
    // until done, then step one more cycle so the DUT is back in IDLE.
    task automatic issue(input logic wr, input int trk, input int pos, input int maddr,
                         input int len, input bit hold,
                         output int cyc, output int nbusy, output int nflag, output int nmw);
        bit got = 0;
        cyc = 0; nbusy = 0; nflag = 0; nmw = 0;
        cmdWrite = wr; cmdTrack = 32'(trk); cmdTrackPos = 32'(pos);
        cmdMemAddr = 32'(maddr); cmdLength = 32'(len); cmdValid = 1'b1;
        @(posedge clock); #1;
        if (!hold) cmdValid = 1'b0;
        else begin
            cmdWrite = ~wr; cmdTrack = 32'd0; cmdLength = 32'd7; cmdMemAddr = 32'd100;
        end
        for (int k = 0; k < 200; k++) begin
            cyc++;
            if (busy)     nbusy++;
            if (hdFlag)   nflag++;
            if (memWrite) nmw++;
            if (done) begin
                cmdValid = 1'b0;
                got = 1;
                break;
            end
            @(posedge clock); #1;
        end
        if (!got) begin
            total++; bad++;
            $display("FAIL done_timeout: got no done want done within 200 cycles");
        end
        @(posedge clock); #1;
        chk("idle_ready", {31'd0, cmdReady}, 32'd1);
    endtask

    int cyc, nb, nf, nm;

    initial begin
        for (int i = 0; i < 1024; i++) disk[i] <= 32'd0;
        for (int i = 0; i < 256; i++)  mem[i]  <= 32'd0;
        disk[256] <= 32'h11; disk[257] <= 32'h22; disk[258] <= 32'h33; disk[259] <= 32'h44;
        mem[0] <= 32'hA; mem[1] <= 32'hB; mem[2] <= 32'hC; mem[3] <= 32'hD; mem[4] <= 32'hE;
        resetN = 1'b0; cmdValid = 1'b0; cmdWrite = 1'b0;
        cmdTrack = '0; cmdTrackPos = '0; cmdMemAddr = '0; cmdLength = '0;
        #1;
        chk("rst_ready",   {31'd0, cmdReady}, 32'd1);
        chk("rst_busy",    {31'd0, busy},     32'd0);
        chk("rst_done",    {31'd0, done},     32'd0);
        chk("rst_error",   {31'd0, error},    32'd0);
        chk("rst_hdflag",  {31'd0, hdFlag},   32'd0);
        chk("rst_memwr",   {31'd0, memWrite}, 32'd0);
        chk("rst_memaddr", memAddress,  32'd0);
        chk("rst_track",   hdTrack,     32'd0);
        chk("rst_pos",     hdTrackPos,  32'd0);
        chk("rst_hdwd",    hdWriteData, 32'd0);
        chk("rst_memwd",   memWriteData, 32'd0);
        chk("rst_csum",    checksum,    32'd0);
        repeat (2) @(posedge clock);
        #1 resetN = 1'b1;
        @(posedge clock); #1;

        // 1: load 4 words track 1 pos 0 -> mem[8..11]
        push(0, 8, 32'h11, 0); push(0, 9, 32'h22, 0);
        push(0, 10, 32'h33, 0); push(0, 11, 32'h44, 0);
        push(2, 0, CS ? 32'hAA : 32'h0, 0);
        issue(1'b0, 1, 0, 8, 4, 0, cyc, nb, nf, nm);
        chk("t1_busy_cycles", 32'(nb), 32'd8);
        chk("t1_memwr_cycles", 32'(nm), 32'd4);
        chk("t1_mem8", mem[8], 32'h11);
        chk("t1_mem11", mem[11], 32'h44);

        // 2: store 3 words with track wrap 2/255 -> 3/0
        push(1, 766, 32'hA, 0); push(1, 767, 32'hB, 0); push(1, 768, 32'hC, 0);
        push(2, 0, CS ? 32'h21 : 32'h0, 0);
        issue(1'b1, 2, 254, 0, 3, 0, cyc, nb, nf, nm);
        chk("t2_hdflag_cycles", 32'(nf), 32'd3);
        chk("t2_busy_cycles", 32'(nb), 32'd3);
        chk("t2_disk768", disk[768], 32'hC);

        // 3: range failures finish the cycle after accept with error
        push(2, 0, 32'h0, 1);
        issue(1'b1, 3, 250, 0, 10, 0, cyc, nb, nf, nm);
        chk("t3a_done_latency", 32'(cyc), 32'd1);
        chk("t3a_err_sticky", {31'd0, error}, 32'd1);
        push(2, 0, 32'h0, 1);
        issue(1'b0, 4, 0, 0, 1, 0, cyc, nb, nf, nm);
        chk("t3b_done_latency", 32'(cyc), 32'd1);
        chk("t3b_access", 32'(nf + nm), 32'd0);

        // 3c: exact fit at the top of the disk is legal
        push(1, 1022, 32'hA, 0); push(1, 1023, 32'hB, 0);
        push(2, 0, CS ? 32'h15 : 32'h0, 0);
        issue(1'b1, 3, 254, 0, 2, 0, cyc, nb, nf, nm);
        chk("t3c_hdflag_cycles", 32'(nf), 32'd2);

        // 4: zero length, then cmdValid held high through a load
        push(2, 0, 32'h0, 0);
        issue(1'b1, 0, 0, 0, 0, 0, cyc, nb, nf, nm);
        chk("t4a_done_latency", 32'(cyc), 32'd1);
        push(0, 20, 32'h11, 0); push(0, 21, 32'h22, 0);
        push(2, 0, CS ? 32'h33 : 32'h0, 0);
        issue(1'b0, 1, 0, 20, 2, 1, cyc, nb, nf, nm);
        chk("t4b_busy_cycles", 32'(nb), 32'd4);
        chk("t4b_no_store", 32'(nf), 32'd0);
        repeat (3) @(posedge clock); #1;
        chk("t4b_no_requeue", {31'd0, busy}, 32'd0);

        // 5: reset in the middle of a 5-word store after 2 words
        push(1, 0, 32'hA, 0); push(1, 1, 32'hB, 0);
        cmdWrite = 1'b1; cmdTrack = 32'd0; cmdTrackPos = 32'd0;
        cmdMemAddr = 32'd0; cmdLength = 32'd5; cmdValid = 1'b1;
        @(posedge clock); #1;
        cmdValid = 1'b0;
        repeat (2) @(posedge clock);
        #1 resetN = 1'b0;
        #1;
        chk("t5_rst_hdflag", {31'd0, hdFlag}, 32'd0);
        chk("t5_rst_busy",   {31'd0, busy},   32'd0);
        chk("t5_rst_ready",  {31'd0, cmdReady}, 32'd1);
        chk("t5_rst_done",   {31'd0, done},   32'd0);
        chk("t5_rst_track",  hdTrackPos, 32'd0);
        @(posedge clock); @(posedge clock); #1;
        resetN = 1'b1;
        chk("t5_disk1_kept", disk[1], 32'hB);
        chk("t5_disk2_untouched", disk[2], 32'h0);
        chk("t5_queue_drained", 32'(q.size()), 32'd0);
        @(posedge clock); #1;
        push(0, 40, 32'hA, 0); push(0, 41, 32'hB, 0);
        push(2, 0, CS ? 32'h15 : 32'h0, 0);
        issue(1'b0, 0, 0, 40, 2, 0, cyc, nb, nf, nm);
        chk("t5_fresh_mem41", mem[41], 32'hB);

        repeat (2) @(posedge clock); #1;
        chk("final_queue_empty", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hd_dma_controller.md
Name: hd_dma_controller

Overview:
Initiator/sequencer for the hard-disk storage block. Accepts one block-transfer command from the CPU side and drives the disk's track/trackPos/writeData/hdFlag interface word by word. Moves data disk->data memory (load) or data memory->disk (store). Owns address generation, track wrap-around, range checking and the completion handshake.

Parameters:
DATA_WIDTH, 32, word width of disk, memory and command fields
ADDR_WIDTH, 1024, total disk words
TRACKS, 4, number of tracks; words per track TPW = ADDR_WIDTH/TRACKS (256 by default)

Ports:
clock  in  1  single system clock, rising edge
resetN  in  1  asynchronous, active-low reset
cmdValid  in  1  command request
cmdReady  out  1  controller can accept a command (state IDLE)
cmdWrite  in  1  1 = memory->disk, 0 = disk->memory
cmdTrack  in  DATA_WIDTH  start track
cmdTrackPos  in  DATA_WIDTH  start position within track
cmdMemAddr  in  DATA_WIDTH  start word address in data memory
cmdLength  in  DATA_WIDTH  number of words
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse
error  out  1  sticky status of last command, valid from done until next accept
checksum  out  DATA_WIDTH  see Optional Feature
hdTrack  out  DATA_WIDTH  disk track
hdTrackPos  out  DATA_WIDTH  disk position
hdWriteData  out  DATA_WIDTH  disk write data
hdFlag  out  1  disk write enable
hdReadData  in  DATA_WIDTH  disk read data, registered: valid one clock after address
memAddress  out  DATA_WIDTH  data memory word address
memWriteData  out  DATA_WIDTH  memory write data
memWrite  out  1  memory write strobe
memReadData  in  DATA_WIDTH  memory read data, combinational on memAddress

Behaviour:
- Reset (async, resetN=0): state IDLE; cmdReady=1; busy=0, done=0, error=0, hdFlag=0, memWrite=0; all address/data outputs 0; checksum 0.
- Accept: cmdValid & cmdReady at a rising edge. Command fields latched; later changes ignored. cmdValid while busy is ignored (no queuing).
- Range check at accept. Fail if cmdTrack>=TRACKS, cmdTrackPos>=TPW, or cmdTrack*TPW+cmdTrackPos+cmdLength > ADDR_WIDTH. Use a width-safe compare with no overflow wrap.
  - On fail: go to DONE, error=1, no hdFlag/memWrite asserted.
- cmdLength=0 with valid range: go to DONE, error=0, no accesses.
- States: IDLE -> (LOAD_ADDR | STORE) -> DONE -> IDLE.
- LOAD_ADDR (disk->memory):
  - Drive hdTrack/hdTrackPos for current word.
  - Next cycle is LOAD_DATA: memAddress = current memory address, memWriteData = hdReadData, memWrite=1.
  - Then advance and return to LOAD_ADDR, or go to DONE after the last word.
  - Throughput: 2 cycles/word.
- STORE (memory->disk):
  - Each cycle drive memAddress; hdWriteData = memReadData, hdFlag=1, hdTrack/hdTrackPos current.
  - Advance each cycle. 1 cycle/word; DONE after the last word.
- Advance:
  - memAddress+1.
  - trackPos+1; if trackPos == TPW-1, trackPos=0 and track+1.
  - Remaining count-1.
- hdFlag and memWrite are never asserted outside STORE / LOAD_DATA respectively, and never together.
- DONE: done=1 for exactly one cycle, busy=0 and cmdReady=1 from the next cycle (IDLE). A new command can be accepted in the cycle after done.
- busy=1 from the cycle after accept through the cycle before done.
- Reset mid-transfer: immediate abort to reset values. Words already written remain; no done pulse.

Optional Feature:
Macro HDC_CHECKSUM_EN.
- Defined:
  - checksum clears at accept.
  - Adds (mod 2^DATA_WIDTH) every word transferred (the memWriteData on load, hdWriteData on store).
  - Holds the final value from done until next accept.
- Undefined: checksum tied to 0 and no adder is built.

Test Plan:
1. Preload disk track 1 pos 0..3 = 0x11,0x22,0x33,0x44; load cmdTrack=1, cmdTrackPos=0, cmdMemAddr=8, cmdLength=4 -> memory[8..11] = 0x11..0x44, 8 busy cycles, one done pulse, error=0, checksum=0xAA when enabled.
2. Memory[0..2] = 0xA,0xB,0xC; store cmdTrack=2, cmdTrackPos=254, length 3 -> disk words 766, 767, 768 written (track wrap 2/255 -> 3/0); hdFlag high exactly 3 cycles.
3. cmdTrack=3, cmdTrackPos=250, length 10 -> error=1, done pulse the cycle after accept, zero hdFlag/memWrite activity; cmdTrack=4 -> same.
4. cmdLength=0 valid range -> done with error=0, no accesses; cmdValid held high during busy -> only the first command executes.
5. Assert resetN=0 mid-store after 2 of 5 words -> outputs reset immediately, no done; a fresh command afterwards completes normally.
